// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and access sequencer for a
// single-port 256x8 memory (write on rising clk, combinational read).
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   reqN/weN/addrN/wdataN    requester N access (held until ackN), N = 0, 1
//   ackN                     one-cycle completion pulse to requester N
//   rdataN                   read data for requester N, valid with ackN
//   mem_addr/mem_in/mem_write  memory drive, non-zero only during ACCESS
//   mem_out                  memory combinational read data
//   gnt_cnt0/gnt_cnt1        saturating 16-bit grant counters, present only
//                            when MEM_ARB_STATS_EN is defined
//
// Optional feature macro: MEM_ARB_STATS_EN

module mem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_write,
  input  logic [DW-1:0] mem_out
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]   gnt_cnt0,
  output logic [15:0]   gnt_cnt1
`endif
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;     // id of the most recent grant
  logic          id_q, id_d;         // granted requester for the ACCESS cycle
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          elig0, elig1;
  logic          grant_v;
  logic          grant_id;

`ifdef MEM_ARB_STATS_EN
  logic [15:0]   gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0]   gnt_cnt1_q, gnt_cnt1_d;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant_v  = 1'b0;
    grant_id = 1'b0;

    // A requester is masked during its own ack cycle so a late req drop
    // cannot cause a second grant.
    elig0 = req0 & ~ack0_q;
    elig1 = req1 & ~ack1_q;

    case (state_q)
      S_IDLE: begin
        if (elig0 || elig1) begin
          grant_v  = 1'b1;
          // On a tie the requester that was not granted last wins.
          grant_id = (elig0 && elig1) ? ~last_q : elig1;
          id_d     = grant_id;
          last_d   = grant_id;
          we_d     = grant_id ? we1    : we0;
          addr_d   = grant_id ? addr1  : addr0;
          wdata_d  = grant_id ? wdata1 : wdata0;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        if (id_q) begin
          ack1_d = 1'b1;
          if (!we_q) rdata1_d = mem_out;
        end else begin
          ack0_d = 1'b1;
          if (!we_q) rdata0_d = mem_out;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (grant_v && !grant_id && gnt_cnt0_q != '1) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (grant_v &&  grant_id && gnt_cnt1_q != '1) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef MEM_ARB_STATS_EN
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
`ifdef MEM_ARB_STATS_EN
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
`endif
    end
  end

  // The memory bus is idle-zero outside ACCESS; rst gates the write so an
  // access interrupted by reset never reaches the array.
  always_comb begin
    mem_addr  = '0;
    mem_in    = '0;
    mem_write = 1'b0;
    if (state_q == S_ACCESS) begin
      mem_addr  = addr_q;
      mem_in    = wdata_q;
      mem_write = we_q & ~rst;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

`ifdef MEM_ARB_STATS_EN
  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// transaction-level scoreboard (reference memory updated in completion order).
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, ack0, req1, we1, ack1;
  logic [7:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
  logic [7:0] mem_addr, mem_in, mem_out;
  logic       mem_write;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 clk = ~clk;

  assign mem_out = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_in;

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_write(mem_write), .mem_out(mem_out)
`ifdef MEM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b expected 0", ack0); end
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1: got %b expected 0", ack1); end
    checks++; if (rdata0 !== 8'h00) begin errors++; $display("FAIL reset_rdata0: got %h expected 00", rdata0); end
    checks++; if (rdata1 !== 8'h00) begin errors++; $display("FAIL reset_rdata1: got %h expected 00", rdata1); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
    checks++; if (mem_in !== 8'h00) begin errors++; $display("FAIL reset_mem_in: got %h expected 00", mem_in); end
  endtask

  task automatic test_write_read();
    mem[8'h10] = 8'h00;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
    cyc();  // ACCESS
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL wr_mem_write: got %b expected 1", mem_write); end
    checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL wr_mem_addr: got %h expected 10", mem_addr); end
    checks++; if (mem_in !== 8'hA5) begin errors++; $display("FAIL wr_mem_in: got %h expected a5", mem_in); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL wr_ack0_early: got %b expected 0", ack0); end
    cyc();  // ack cycle
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL wr_ack0: got %b expected 1", ack0); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL wr_single_write: got %b expected 0", mem_write); end
    req0 = 1'b0;
    cyc();
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL wr_ack0_pulse: got %b expected 0", ack0); end
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    cyc();
    cyc();
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL rd_ack1: got %b expected 1", ack1); end
    checks++; if (rdata1 !== 8'hA5) begin errors++; $display("FAIL rd_rdata1: got %h expected a5", rdata1); end
    req1 = 1'b0;
    cyc();
  endtask

  task automatic test_tie();
    logic [7:0] v0, v1;
    v0 = 8'($urandom); v1 = 8'($urandom);
    do_reset();
    mem[8'h30] = v0; mem[8'h31] = v1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
    cyc();
    checks++; if (mem_addr !== 8'h30) begin errors++; $display("FAIL tie_first_grant: got addr %h expected 30", mem_addr); end
    cyc();
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL tie_ack0: got %b expected 1", ack0); end
    checks++; if (rdata0 !== v0) begin errors++; $display("FAIL tie_rdata0: got %h expected %h", rdata0, v0); end
    req0 = 1'b0;
    cyc();
    checks++; if (mem_addr !== 8'h31 || ack1 !== 1'b0) begin errors++; $display("FAIL tie_second_grant: got addr %h ack1 %b expected 31 0", mem_addr, ack1); end
    cyc();
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL tie_ack1: got %b expected 1", ack1); end
    checks++; if (rdata1 !== v1) begin errors++; $display("FAIL tie_rdata1: got %h expected %h", rdata1, v1); end
    req1 = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    int n_ack, tmo, exp_id;
    do_reset();
    n_ack = 0; tmo = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'($urandom);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'($urandom);
    while (n_ack < 8 && tmo < 40) begin
      cyc();
      tmo++;
      exp_id = n_ack % 2;
      if (ack0) begin
        checks++; if (exp_id !== 0) begin errors++; $display("FAIL b2b_order: access %0d got port 0 expected port %0d", n_ack, exp_id); end
        checks++; if (rdata0 !== mem[addr0]) begin errors++; $display("FAIL b2b_rdata0: got %h expected %h", rdata0, mem[addr0]); end
        n_ack++;
        addr0 = 8'($urandom);
      end
      if (ack1) begin
        checks++; if (exp_id !== 1) begin errors++; $display("FAIL b2b_order: access %0d got port 1 expected port %0d", n_ack, exp_id); end
        checks++; if (rdata1 !== mem[addr1]) begin errors++; $display("FAIL b2b_rdata1: got %h expected %h", rdata1, mem[addr1]); end
        n_ack++;
        addr1 = 8'($urandom);
      end
    end
    checks++; if (n_ack !== 8) begin errors++; $display("FAIL b2b_count: got %0d acks expected 8", n_ack); end
    checks++; if (tmo > 17) begin errors++; $display("FAIL b2b_rate: got %0d cycles expected at most 17", tmo); end
    req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_late_drop();
    int nw, na;
    bit drop_next;
    logic [7:0] d;
    nw = 0; na = 0; drop_next = 1'b0;
    d = 8'($urandom);
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = d;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (mem_write) nw++;
      if (ack0) begin
        na++;
        drop_next = 1'b1;   // keep req0 high through the ack cycle
      end else if (drop_next) begin
        req0 = 1'b0;
      end
    end
    checks++; if (nw !== 1) begin errors++; $display("FAIL late_drop_writes: got %0d expected 1", nw); end
    checks++; if (na !== 1) begin errors++; $display("FAIL late_drop_acks: got %0d expected 1", na); end
    checks++; if (mem[8'h40] !== d) begin errors++; $display("FAIL late_drop_data: got %h expected %h", mem[8'h40], d); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] a0, a1;
    bit seen;
    mem[8'h20] = 8'h77;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 8'h3C;
    cyc();  // ACCESS
    rst = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL abort_write_gated: got %b expected 0", mem_write); end
    cyc();
    req0 = 1'b0;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL abort_ack0: got %b expected 0", ack0); end
    checks++; if (mem[8'h20] !== 8'h77) begin errors++; $display("FAIL abort_mem: got %h expected 77", mem[8'h20]); end
    checks++; if (mem_write !== 1'b0 || mem_addr !== 8'h00 || mem_in !== 8'h00) begin errors++; $display("FAIL abort_bus: got we %b addr %h in %h expected 0 00 00", mem_write, mem_addr, mem_in); end
    checks++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin errors++; $display("FAIL abort_rdata: got %h %h expected 00 00", rdata0, rdata1); end
    rst = 1'b0;
    cyc();
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL abort_late_ack0: got %b expected 0", ack0); end
    a0 = 8'($urandom); a1 = a0 ^ 8'h5A;
    req0 = 1'b1; we0 = 1'b0; addr0 = a0;
    req1 = 1'b1; we1 = 1'b0; addr1 = a1;
    cyc();
    checks++; if (mem_addr !== a0) begin errors++; $display("FAIL abort_idle_grant: got addr %h expected %h", mem_addr, a0); end
    cyc();
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL abort_idle_ack0: got %b expected 1", ack0); end
    req0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      cyc();
      if (ack1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL abort_ack1_timeout: got no ack1 expected ack1 within 4 cycles"); end
    req1 = 1'b0;
    cyc();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    bit seen;
    do_reset();
    checks++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d %0d expected 0 0", gnt_cnt0, gnt_cnt1); end
    for (int i = 0; i < 8; i++) begin
      seen = 1'b0;
      if (i < 3) begin req0 = 1'b1; we0 = 1'b0; addr0 = 8'(i); end
      else       begin req1 = 1'b1; we1 = 1'b0; addr1 = 8'(i); end
      for (int k = 0; k < 6 && !seen; k++) begin
        cyc();
        if (ack0 || ack1) seen = 1'b1;
      end
      req0 = 1'b0; req1 = 1'b0;
      cyc();
    end
    checks++; if (gnt_cnt0 !== 16'd3) begin errors++; $display("FAIL stats_cnt0: got %0d expected 3", gnt_cnt0); end
    checks++; if (gnt_cnt1 !== 16'd5) begin errors++; $display("FAIL stats_cnt1: got %0d expected 5", gnt_cnt1); end
    do_reset();
    checks++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin errors++; $display("FAIL stats_clear: got %0d %0d expected 0 0", gnt_cnt0, gnt_cnt1); end
  endtask
`endif

  task automatic test_random();
    bit         pend [2];
    bit         just [2];
    bit         pwe  [2];
    logic [7:0] paddr [2];
    logic [7:0] pwdata [2];
    int         pstart [2];
    logic       a;
    logic [7:0] rd;
    int         lat;
    bit         match;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int p = 0; p < 2; p++) begin pend[p] = 0; just[p] = 0; end
    for (int c = 0; c < 310; c++) begin
      cyc();
      if (mem_write) begin
        match = 1'b0;
        for (int p = 0; p < 2; p++)
          if (pend[p] && pwe[p] && paddr[p] == mem_addr && pwdata[p] == mem_in) match = 1'b1;
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL rand_write_bus: got addr %h data %h matching no pending write", mem_addr, mem_in); end
      end
      for (int p = 0; p < 2; p++) begin
        a  = (p == 1) ? ack1 : ack0;
        rd = (p == 1) ? rdata1 : rdata0;
        just[p] = a;
        if (a) begin
          checks++;
          if (!pend[p]) begin
            errors++; $display("FAIL rand_spurious_ack: port %0d got ack expected none", p);
          end else begin
            lat = cycle - pstart[p];
            if (lat < 2 || lat > 4) begin errors++; $display("FAIL rand_latency: port %0d got %0d cycles expected 2..4", p, lat); end
            if (!pwe[p]) begin
              checks++; if (rd !== ref_mem[paddr[p]]) begin errors++; $display("FAIL rand_rdata: port %0d addr %h got %h expected %h", p, paddr[p], rd, ref_mem[paddr[p]]); end
            end else begin
              ref_mem[paddr[p]] = pwdata[p];
            end
            pend[p] = 1'b0;
          end
        end else if (pend[p] && (cycle - pstart[p]) > 4) begin
          checks++; errors++;
          $display("FAIL rand_starve: port %0d got no ack after %0d cycles expected at most 4", p, cycle - pstart[p]);
          pend[p] = 1'b0;
        end
        if (c < 300 && !pend[p] && !just[p] && $urandom_range(0, 1) == 1) begin
          pend[p]   = 1'b1;
          pwe[p]    = 1'($urandom);
          paddr[p]  = 8'($urandom_range(0, 7));
          pwdata[p] = 8'($urandom);
          pstart[p] = cycle;
        end
      end
      req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pwdata[0];
      req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pwdata[1];
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_final_mem: addr %0d got %h expected %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_late_drop();
    test_reset_abort();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester round-robin arbiter and access sequencer for the team's single-port 256x8 memory (8-bit address, 8-bit write data, write on rising clk, asynchronous read).
- Sits between the memory and two masters, e.g. instruction fetch (port 0) and data load/store (port 1).
- Serialises their accesses and returns registered read data with a one-cycle ack pulse.

Parameters:
AW, 8, address width; must match the memory depth of 256.
DW, 8, data width; must match the memory word.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
req0  input  1  requester 0 access request; held until ack0.
we0  input  1  requester 0: 1 = write, 0 = read; stable while req0.
addr0  input  AW  requester 0 address; stable while req0.
wdata0  input  DW  requester 0 write data; stable while req0.
ack0  output  1  one-cycle completion pulse to requester 0.
rdata0  output  DW  requester 0 read data; valid when ack0 = 1.
req1, we1, addr1, wdata1, ack1, rdata1: same as above, for requester 1.
mem_addr  output  AW  drives memory addr.
mem_in  output  DW  drives memory in.
mem_write  output  1  drives memory write.
mem_out  input  DW  memory out (combinational read).

Behaviour:
- One clock, clk. rst is synchronous and active-high; all state updates on the rising edge of clk.
- FSM states: IDLE, ACCESS. Reset state is IDLE.
- Reset values:
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0.
  - last-grant pointer = 1, so requester 0 wins the first tie.
  - latched request registers = 0.
- IDLE:
  - Eligible requesters: reqN = 1 and ackN = 0. A requester is masked during its own ack cycle, so no double grant occurs if it drops req late.
  - No eligible requester: stay in IDLE.
  - One eligible: grant it.
  - Both eligible: grant the one not equal to the last-grant pointer.
  - On grant: latch id, we, addr and wdata; update the pointer; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr; mem_in = latched wdata; mem_write = latched we & ~rst.
  - At the closing edge: for a read, capture mem_out into rdataN of the granted requester; for a write, leave rdataN unchanged.
  - Also at the closing edge: set ackN = 1 and return to IDLE.
- ack is high for exactly one cycle, in the IDLE cycle that follows ACCESS.
- Outside ACCESS: mem_write = 0 and mem_addr = mem_in = 0. A write is never issued outside ACCESS.
- Latency and throughput:
  - req sampled in cycle N gives ACCESS in N+1 and ack in N+2.
  - Maximum throughput is one access per 2 cycles.
  - Under continuous requests from both masters, grants alternate 0,1,0,1.
- The requester must deassert req, or present a new request, in the cycle after it sees ack. A new request from the same requester is eligible from the cycle after its ack.
- Reset mid-operation: rst high during ACCESS suppresses the memory write (mem_write gated), produces no ack, and returns the FSM to IDLE.
- Address and data widths pass straight through; no arithmetic on address.
- rdataN holds its value until the next read completion for that requester.

Optional Feature:
Macro: MEM_ARB_STATS_EN.
- Defined: adds outputs gnt_cnt0 and gnt_cnt1, 16 bits each.
  - Each counter increments on every IDLE-to-ACCESS grant to its requester.
  - Counters saturate at 16'hFFFF and clear to 0 on rst.
  - A grant aborted by rst is not counted.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then write port 0 (req0 = 1, we0 = 1, addr0 = 8'h10, wdata0 = 8'hA5) -> mem_write = 1 for exactly one cycle with mem_addr = 8'h10; ack0 pulses 2 cycles after req0; a subsequent port 1 read of 8'h10 returns rdata1 = 8'hA5 with ack1.
- req0 and req1 both reads, asserted in the same cycle straight after reset -> port 0 is granted first and port 1 next; ack0 at N+2, ack1 at N+4; rdata values match preloaded memory contents.
- Both requesters continuously requesting for 8 accesses -> grant order 0,1,0,1,0,1,0,1; no requester starved.
- req0 held high for one extra cycle after ack0 -> no second access is issued in that ack cycle; exactly one mem_write/ack per intended request.
- rst asserted during an ACCESS write to 8'h20 (wdata 8'h3C) -> no ack, the word at 8'h20 is unchanged, and the FSM is in IDLE with all outputs at reset values.
- With MEM_ARB_STATS_EN defined: 3 grants to port 0 and 5 to port 1 -> gnt_cnt0 = 3, gnt_cnt1 = 5; after rst both read 0.
